sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Message-schedule stage of the SHA-256 core. It accepts one 512-bit block as 16 serial 32-bit words and streams the 64 schedule words W[0..63], one per handshake. Each new word is formed by a four-operand modulo-2^32 addition. The consumer is the round/compression datapath, whose 32-bit adders take W[t] as an operand.

## Interface
Parameters:
- ROUNDS, 64, number of schedule words emitted per block (fixed for SHA-256)
- WORD_W, 32, word width (fixed)

Ports:
- i_clk  in  1  clock; every register updates on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_load_valid  in  1  i_load_word is valid
- o_load_ready  out  1  block accepts a message word
- i_load_word  in  32  message word, M[0] first
- o_w_valid  out  1  o_w/o_w_idx are valid
- i_w_ready  in  1  consumer takes o_w this cycle
- o_w  out  32  schedule word W[o_w_idx]
- o_w_idx  out  6  round index t, 0..63
- o_done  out  1  one-cycle pulse after W[63] is accepted

## Operation
- State is a 16-entry × 32-bit shift window win[0..15] and a 6-bit counter cnt.
- FSM states: LOAD and STREAM. Reset state is LOAD.
- LOAD:
  - o_load_ready=1, o_w_valid=0.
  - On each load handshake (i_load_valid & o_load_ready), the window shifts toward index 0: win[i]<=win[i+1], win[15]<=i_load_word. Then cnt++.
  - On the 16th handshake (cnt==15), cnt<=0 and the FSM moves to STREAM.
  - Gaps in i_load_valid are allowed.
- STREAM:
  - o_load_ready=0, o_w_valid=1, o_w=win[0], o_w_idx=cnt.
  - On each output handshake, the window shifts toward index 0 and win[15]<=nxt, where nxt = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32 (carries discarded).
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Result: W[0..15] = M[0..15] and W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] for t ≥ 16. Words computed after t=63 are discarded.
  - On the handshake with cnt==63: cnt<=0, FSM to LOAD, o_done<=1 for the next cycle only.
- Boundary cases:
  - i_load_valid is ignored in STREAM.
  - i_w_ready is ignored in LOAD.
  - i_w_ready=0 stalls: window, cnt, o_w and o_w_idx hold stable. o_w_valid stays high and is never withdrawn without a handshake.
  - Reset mid-load or mid-stream discards the partial block: FSM to LOAD, cnt=0, window cleared.

## Timing
- Reset values (cycle after i_rst high):
  - o_load_ready=1, o_w_valid=0, o_w=0, o_w_idx=0, o_done=0.
  - Window all zero, cnt=0.
- i_rst takes priority over every handshake in the same cycle.
- Outputs come from registers or decode FSM state only. The nxt adder path is the only combinational arithmetic and ends at win[15].
- 16th load handshake in cycle N → o_w_valid=1 with W[0] in cycle N+1.
- With i_w_ready held at 1: W[t] is presented in cycle N+1+t, and W[63] in cycle N+64.
- o_done=1 and o_load_ready=1 in cycle N+65.
- Minimum block turnaround is 80 cycles (16 load + 64 stream), with no dead cycle between blocks.
- Throughput is one word per cycle in each phase.

## Test plan
- "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), i_w_ready=1:
  - W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000.
  - Idx sequence 0..63 with no gaps; o_done pulses exactly once, one cycle after idx 63.
- All-ones block (16× 0xFFFFFFFF) → W[16]=0x203FFFFC (modulo wrap checked). All 64 words match the reference model.
- Backpressure: toggle i_w_ready pseudo-randomly during the "abc" stream → o_w/o_w_idx stable while stalled, no word skipped or repeated, same 64 values as the unstalled run.
- Load gaps: i_load_valid toggled 1-0-1…, plus i_load_valid=1 held during STREAM → only 16 words captured per block; o_load_ready=0 throughout STREAM.
- Reset mid-operation:
  - Assert i_rst at idx 30 → next cycle o_w_valid=0, o_load_ready=1, o_w_idx=0.
  - A fresh "abc" block then yields W[16]=0x61626380.
- Back-to-back blocks: second block loaded starting in the o_done cycle → its W[0] appears exactly 16 load handshakes later; no residue from the first block.

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - load and schedule-word stream bundle for the SHA-256 message schedule
interface sha256_msg_schedule_if #(
    parameter int WORD_W = 32
);
    logic              i_load_valid;
    logic              o_load_ready;
    logic [WORD_W-1:0] i_load_word;
    logic              o_w_valid;
    logic              i_w_ready;
    logic [WORD_W-1:0] o_w;
    logic [5:0]        o_w_idx;
    logic              o_done;

    modport slave (
        input  i_load_valid, i_load_word, i_w_ready,
        output o_load_ready, o_w_valid, o_w, o_w_idx, o_done
    );

    modport master (
        output i_load_valid, i_load_word, i_w_ready,
        input  o_load_ready, o_w_valid, o_w, o_w_idx, o_done
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule: 16 words in, W[0..63] out
module sha256_msg_schedule #(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    sha256_msg_schedule_if.slave   bus
);
    typedef enum logic {ST_LOAD, ST_STREAM} state_t;

    localparam logic [5:0] LAST_LOAD = 6'd15;
    localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [5:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] nxt;
    logic              load_hs, w_hs;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Window slot 0 holds W[t], so slots 1/9/14 are W[t+1], W[t+9], W[t+14].
    assign nxt     = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    assign load_hs = (state_q == ST_LOAD)   && bus.i_load_valid;
    assign w_hs    = (state_q == ST_STREAM) && bus.i_w_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        if (load_hs || w_hs) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = load_hs ? bus.i_load_word : nxt;
        end

        case (state_q)
            ST_LOAD: begin
                if (load_hs) begin
                    if (cnt_q == LAST_LOAD) begin
                        cnt_d   = '0;
                        state_d = ST_STREAM;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_STREAM: begin
                if (w_hs) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign bus.o_load_ready = (state_q == ST_LOAD);
    assign bus.o_w_valid    = (state_q == ST_STREAM);
    assign bus.o_w          = win_q[0];
    assign bus.o_w_idx      = cnt_q;
    assign bus.o_done       = done_q;
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - scoreboard bench for the SHA-256 message schedule
module tb_sha256_msg_schedule;
    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sched_t [64];
    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_schedule_if #(.WORD_W(32)) bus ();

    sha256_msg_schedule #(.ROUNDS(64), .WORD_W(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          fails  = 0;
    exp_t        sb [$];
    logic [31:0] got [64];
    bit          rdy_random = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t ref_schedule(input blk_t m);
        sched_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = m[t];
            end else begin
                w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10))
                     + w[t-7]
                     + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
                     + w[t-16];
            end
        end
        return w;
    endfunction

    task automatic push_expected(input blk_t m);
        sched_t w;
        w = ref_schedule(m);
        for (int t = 0; t < 64; t++) begin
            sb.push_back({6'(t), w[t]});
            got[t] = 32'hDEAD_BEEF;
        end
    endtask

    // Consumer-side ready: either held high or coin-flipped every cycle.
    always @(posedge clk) begin
        #1;
        bus.i_w_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: samples on the falling edge, handshakes complete on the next rising edge.
    bit          stall_pend = 1'b0;
    bit          exp_done   = 1'b0;
    logic [31:0] prev_w;
    logic [5:0]  prev_idx;

    always @(negedge clk) begin
        exp_t e;
        bit   next_done;
        if (rst) begin
            stall_pend = 1'b0;
            exp_done   = 1'b0;
        end else begin
            next_done = 1'b0;
            chk("done_pulse", 32'(bus.o_done), 32'(exp_done));
            if (bus.o_w_valid && bus.o_load_ready) begin
                chk("ready_valid_exclusive", 32'(bus.o_load_ready), 32'd0);
            end
            if (stall_pend) begin
                chk("stall_valid", 32'(bus.o_w_valid), 32'd1);
                chk("stall_w", bus.o_w, prev_w);
                chk("stall_idx", 32'(bus.o_w_idx), 32'(prev_idx));
            end
            if (bus.o_w_valid && bus.i_w_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'(bus.o_w_idx), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("w_idx", 32'(bus.o_w_idx), 32'(e.idx));
                    chk("w_value", bus.o_w, e.w);
                    got[bus.o_w_idx] = bus.o_w;
                    if (bus.o_w_idx == 6'd63) next_done = 1'b1;
                end
            end
            stall_pend = bus.o_w_valid && !bus.i_w_ready;
            prev_w     = bus.o_w;
            prev_idx   = bus.o_w_idx;
            exp_done   = next_done;
        end
    end

    task automatic load_block(input blk_t m, input bit gaps, input bit hold_valid);
        int n;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                bus.i_load_valid = 1'b0;
                bus.i_load_word  = $urandom;
                @(posedge clk); #1;
            end
            bus.i_load_valid = 1'b1;
            bus.i_load_word  = m[i];
            n = 0;
            while (!bus.o_load_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 200) chk("load_ready_timeout", 32'(n), 32'd0);
            @(posedge clk); #1;
        end
        bus.i_load_valid = hold_valid;
        bus.i_load_word  = $urandom;
        chk("w0_latency_valid", 32'(bus.o_w_valid), 32'd1);
        chk("w0_latency_load_ready", 32'(bus.o_load_ready), 32'd0);
    endtask

    task automatic wait_stream_end();
        int n = 0;
        while ((sb.size() != 0 || !bus.o_load_ready) && n < 2000) begin
            if (bus.i_load_valid) bus.i_load_word = $urandom;
            @(posedge clk); #1;
            n++;
        end
        chk("stream_end_timeout", 32'(n < 2000), 32'd1);
        bus.i_load_valid = 1'b0;
    endtask

    blk_t abc, ones, rnd;

    initial begin
        int n;
        bus.i_load_valid = 1'b0;
        bus.i_load_word  = '0;
        bus.i_w_ready    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            abc[i]  = '0;
            ones[i] = 32'hFFFF_FFFF;
        end
        abc[0]  = 32'h6162_6380;
        abc[15] = 32'h0000_0018;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_ready", 32'(bus.o_load_ready), 32'd1);
        chk("rst_w_valid", 32'(bus.o_w_valid), 32'd0);
        chk("rst_w", bus.o_w, 32'd0);
        chk("rst_w_idx", 32'(bus.o_w_idx), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        rst = 1'b0;

        // "abc" with ready held high, exact done timing, then back-to-back all-ones block.
        rdy_random = 1'b0;
        push_expected(abc);
        load_block(abc, 1'b0, 1'b0);
        repeat (64) @(posedge clk);
        #1;
        chk("done_at_n65", 32'(bus.o_done), 32'd1);
        chk("load_ready_at_n65", 32'(bus.o_load_ready), 32'd1);
        chk("abc_w0", got[0], 32'h6162_6380);
        chk("abc_w15", got[15], 32'h0000_0018);
        chk("abc_w16", got[16], 32'h6162_6380);
        chk("abc_w17", got[17], 32'h000F_0000);
        push_expected(ones);
        load_block(ones, 1'b0, 1'b0);
        wait_stream_end();
        chk("ones_w16", got[16], 32'h203F_FFFC);

        // Backpressure on the "abc" stream.
        rdy_random = 1'b1;
        push_expected(abc);
        load_block(abc, 1'b0, 1'b0);
        wait_stream_end();
        chk("bp_abc_w16", got[16], 32'h6162_6380);
        chk("bp_abc_w17", got[17], 32'h000F_0000);

        // Load gaps and load_valid held high during the stream.
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        push_expected(rnd);
        load_block(rnd, 1'b1, 1'b1);
        wait_stream_end();

        // Reset at idx 30, then a fresh "abc" block.
        rdy_random = 1'b0;
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        push_expected(rnd);
        load_block(rnd, 1'b0, 1'b0);
        n = 0;
        while (bus.o_w_idx != 6'd30 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_idx30", 32'(bus.o_w_idx), 32'd30);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_w_valid", 32'(bus.o_w_valid), 32'd0);
        chk("midrst_load_ready", 32'(bus.o_load_ready), 32'd1);
        chk("midrst_w_idx", 32'(bus.o_w_idx), 32'd0);
        chk("midrst_w", bus.o_w, 32'd0);
        chk("midrst_done", 32'(bus.o_done), 32'd0);
        push_expected(abc);
        load_block(abc, 1'b0, 1'b0);
        wait_stream_end();
        chk("postrst_abc_w16", got[16], 32'h6162_6380);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
